// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed N-digit 7-segment scan driver
//
// Latches a packed hex word, decodes each nibble to 7-segment form and
// time-multiplexes the digits onto one shared segment bus with one-hot digit
// selects. Each digit slot begins with a short all-off gap so the previous
// digit's segments cannot ghost onto the next one. New values are taken into
// the display only at a frame boundary, so a frame never mixes two values.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low
//   enable      1: scanning runs; 0: display dark, scan position reset
//   load        1-cycle strobe capturing data/dp into the pending registers
//   data        4*NUM_DIGITS packed nibbles, nibble 0 = least significant digit
//   dp          decimal point per digit
//   lz_blank    1: suppress leading zeros (digit 0 always shown)
//   seg         {dp,g,f,e,d,c,b,a}, inverted when SEG_ACT_LOW=1
//   dig         one-hot digit select, inverted when DIG_ACT_LOW=1
//   frame_done  1-cycle pulse in the last cycle of each full scan frame

module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int SEG_ACT_LOW  = 0,
  parameter int DIG_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_blank,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_L  = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Pin-level "off" patterns. XOR-ing an active-high value with these gives
  // the pin value for either polarity.
  localparam logic [7:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_vld;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic                    running;

  logic                  slot_end;
  logic                  frame_end;
  logic                  copy;
  logic                  in_gap;
  logic [NUM_DIGITS-1:0] zero_from;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [7:0]            seg_ah;
  logic [NUM_DIGITS-1:0] dig_ah;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg_decode = 7'h3F;
      4'h1:    seg_decode = 7'h06;
      4'h2:    seg_decode = 7'h5B;
      4'h3:    seg_decode = 7'h4F;
      4'h4:    seg_decode = 7'h66;
      4'h5:    seg_decode = 7'h6D;
      4'h6:    seg_decode = 7'h7D;
      4'h7:    seg_decode = 7'h27;
      4'h8:    seg_decode = 7'h7F;
      4'h9:    seg_decode = 7'h67;
      4'hA:    seg_decode = 7'h77;
      4'hB:    seg_decode = 7'h7C;
      4'hC:    seg_decode = 7'h39;
      4'hD:    seg_decode = 7'h5E;
      4'hE:    seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    logic acc;
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    // Copy at a frame boundary, or on the first enabled cycle after the
    // display was dark (scan position is already at frame start then).
    copy      = enable && pend_vld && (frame_end || !running);
    in_gap    = (cnt < BLANK_L);

    // zero_from[i]: digit i and every digit above it are zero.
    zero_from = '0;
    acc       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc && (act_data[4*i +: 4] == 4'h0);
      zero_from[i] = acc;
    end

    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    dig_ah    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        cur_nib   = act_data[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = lz_blank && (i != 0) && zero_from[i];
        dig_ah[i] = 1'b1;
      end
    end

    seg_ah = {cur_dp, cur_blank ? 7'h00 : seg_decode(cur_nib)};
  end

  assign frame_done = enable && frame_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_vld  <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
      running   <= 1'b0;
      seg       <= SEG_OFF;
      dig       <= DIG_OFF;
    end else begin
      running <= enable;

      // A load coinciding with the copy stays pending for the next frame.
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp;
        pend_vld  <= 1'b1;
      end else if (copy) begin
        pend_vld  <= 1'b0;
      end

      if (copy) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end

      if (!enable) begin
        cnt <= '0;
        idx <= '0;
        seg <= SEG_OFF;
        dig <= DIG_OFF;
      end else begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end

        if (in_gap) begin
          seg <= SEG_OFF;
          dig <= DIG_OFF;
        end else begin
          seg <= seg_ah ^ SEG_OFF;
          dig <= dig_ah ^ DIG_OFF;
        end
      end
    end
  end

endmodule
